// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator with framebuffer fetch.
// Runs the horizontal/vertical beam counters, issues framebuffer reads ahead
// of the beam to cover FETCH_LAT cycles of RAM latency, and delays sync,
// blank, coordinates and frame_start so every output describes one pixel.
//
// Ports:
//   clk          pixel-rate clock
//   reset        asynchronous, active-high
//   pix_en       pixel clock enable; every register advances only when high
//   rgb_in       framebuffer read data {R,G,B}, valid FETCH_LAT pix_en cycles
//                after fb_rd/fb_addr
//   fb_rd        framebuffer read strobe
//   fb_addr      framebuffer read address
//   rgb_out      pixel colour, zero when blanked
//   hsync/vsync  sync outputs, active level = SYNC_POL
//   de           data enable (active video)
//   x, y         coordinates of the current rgb_out pixel (0 when blanked)
//   frame_start  one-pix_en pulse at the first active pixel of a frame
//
// Build option:
//   VGA_SCALE2_EN  pixel doubling; framebuffer holds (H_DISP/2)x(V_DISP/2)
//                  pixels, each read for 2 pixels on 2 consecutive lines.
//
// FETCH_LAT is expected in 0..7; output latency is L = FETCH_LAT+2 pix_en
// cycles from the counters.

module vga_timing_gen #(
    parameter int unsigned H_DISP    = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_PW      = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISP    = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_PW      = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned COLOR_W   = 4,
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned FETCH_LAT = 1,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_en,
    input  logic [3*COLOR_W-1:0]   rgb_in,
    output logic                   fb_rd,
    output logic [ADDR_W-1:0]      fb_addr,
    output logic [3*COLOR_W-1:0]   rgb_out,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [9:0]             x,
    output logic [9:0]             y,
    output logic                   frame_start
);

    localparam int unsigned H_TOTAL = H_DISP + H_FP + H_PW + H_BP;
    localparam int unsigned V_TOTAL = V_DISP + V_FP + V_PW + V_BP;
    localparam int unsigned HCW     = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VCW     = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned L       = FETCH_LAT + 2;
    localparam int unsigned RGB_W   = 3 * COLOR_W;

    localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);

    // Per-pixel attributes carried down the delay line
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
    } px_t;

    localparam px_t PX_RST = px_t'({~SYNC_POL, ~SYNC_POL, 1'b0, 10'd0, 10'd0, 1'b0});

    logic [HCW-1:0]    hcnt;
    logic [VCW-1:0]    vcnt;
    logic              active_c;
    logic [ADDR_W-1:0] addr_c;
    px_t               px0_c;
    px_t               pipe [L];

    // Beam counters; both wrap together at the last pixel of the frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VCW'(1);
            end else begin
                hcnt <= hcnt + HCW'(1);
            end
        end
    end

    // Stage-0 decode of the counters
    always_comb begin
        px0_c    = PX_RST;
        active_c = (32'(hcnt) < H_DISP) && (32'(vcnt) < V_DISP);
        px0_c.hs = ((32'(hcnt) >= H_DISP + H_FP) && (32'(hcnt) < H_DISP + H_FP + H_PW))
                   ? SYNC_POL : ~SYNC_POL;
        px0_c.vs = ((32'(vcnt) >= V_DISP + V_FP) && (32'(vcnt) < V_DISP + V_FP + V_PW))
                   ? SYNC_POL : ~SYNC_POL;
        px0_c.de = active_c;
        px0_c.x  = active_c ? 10'(hcnt) : 10'd0;
        px0_c.y  = active_c ? 10'(vcnt) : 10'd0;
        px0_c.fs = (hcnt == '0) && (vcnt == '0);
    end

`ifdef VGA_SCALE2_EN
    // Each framebuffer pixel covers a 2x2 block of screen pixels
    always_comb begin
        addr_c = ADDR_W'((32'(vcnt) >> 1) * (H_DISP / 2) + (32'(hcnt) >> 1));
    end
`else
    logic [ADDR_W-1:0] addr_nxt;

    // Linear address restarts at the top-left pixel, so it never runs past
    // the last framebuffer word.
    always_comb begin
        addr_c = ((hcnt == '0) && (vcnt == '0)) ? '0 : addr_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_nxt <= '0;
        end else if (pix_en) begin
            addr_nxt <= active_c ? addr_c + ADDR_W'(1) : addr_c;
        end
    end
`endif

    // Stage 1: framebuffer request; address holds outside active video
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_rd   <= 1'b0;
            fb_addr <= '0;
        end else if (pix_en) begin
            fb_rd <= active_c;
            if (active_c) begin
                fb_addr <= addr_c;
            end
        end
    end

    // Attribute delay line; pipe[L-2] lines up with rgb_in, pipe[L-1] with rgb_out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(L); i++) begin
                pipe[i] <= PX_RST;
            end
        end else if (pix_en) begin
            pipe[0] <= px0_c;
            for (int i = 1; i < int'(L); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Colour output register, blanked outside active video
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_out <= '0;
        end else if (pix_en) begin
            rgb_out <= pipe[L-2].de ? rgb_in : RGB_W'(0);
        end
    end

    assign hsync       = pipe[L-1].hs;
    assign vsync       = pipe[L-1].vs;
    assign de          = pipe[L-1].de;
    assign x           = pipe[L-1].x;
    assign y           = pipe[L-1].y;
    assign frame_start = pipe[L-1].fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// Instance s_dut: small raster (H 8/2/2/2, V 4/1/1/1), FETCH_LAT=3, active-low
// sync, fed by a RAM model returning data = address.
// Instance d_dut: default 640x480 timing, FETCH_LAT=1, active-high sync.

module tb_vga_timing_gen;

    localparam int S_HD = 8;
    localparam int S_HT = 14;
    localparam int S_VD = 4;
    localparam int S_VT = 7;
    localparam int S_FR = S_HT * S_VT;
    localparam int S_FL = 3;
    localparam int S_L  = S_FL + 2;
    localparam int S_AW = 8;

    logic        clk;
    logic        reset;
    logic        pix_en;

    logic [11:0]     s_rgb_in;
    logic            s_fb_rd;
    logic [S_AW-1:0] s_fb_addr;
    logic [11:0]     s_rgb_out;
    logic            s_hsync, s_vsync, s_de, s_fs;
    logic [9:0]      s_x, s_y;

    logic [11:0] d_rgb_in;
    logic        d_fb_rd;
    logic [18:0] d_fb_addr;
    logic [11:0] d_rgb_out;
    logic        d_hsync, d_vsync, d_de, d_fs;
    logic [9:0]  d_x, d_y;

    int checks   = 0;
    int failures = 0;
    int n        = 0;
    int de_seen  = 0;
    int rise1, rise2, fall1;
    logic prev2;

    logic [S_AW-1:0] ram_pipe [S_FL];

    vga_timing_gen #(
        .H_DISP(8), .H_FP(2), .H_PW(2), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_PW(1), .V_BP(1),
        .COLOR_W(4), .ADDR_W(S_AW), .FETCH_LAT(S_FL), .SYNC_POL(1'b0)
    ) s_dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .rgb_in(s_rgb_in),
        .fb_rd(s_fb_rd), .fb_addr(s_fb_addr), .rgb_out(s_rgb_out),
        .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .x(s_x), .y(s_y),
        .frame_start(s_fs)
    );

    vga_timing_gen #(
        .FETCH_LAT(1), .SYNC_POL(1'b1)
    ) d_dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .rgb_in(d_rgb_in),
        .fb_rd(d_fb_rd), .fb_addr(d_fb_addr), .rgb_out(d_rgb_out),
        .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .x(d_x), .y(d_y),
        .frame_start(d_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer model: data = address, FETCH_LAT pix_en cycles later
    always @(posedge clk) begin
        if (pix_en) begin
            ram_pipe[0] <= s_fb_addr;
            for (int i = 1; i < S_FL; i++) ram_pipe[i] <= ram_pipe[i-1];
        end
    end
    assign s_rgb_in = 12'(ram_pipe[S_FL-1]);
    assign d_rgb_in = 12'habc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    function automatic int pix_addr(input int h, input int v);
`ifdef VGA_SCALE2_EN
        return (v / 2) * (S_HD / 2) + h / 2;
`else
        return v * S_HD + h;
`endif
    endfunction

    // Expected small-instance outputs after n pix_en cycles since reset release
    task automatic check_small();
        int p, h, v, p1, h1, v1;
        logic act, act1;
        if (reset || n < S_L) begin
            chk("s_de_rst", s_de, 0);
            chk("s_x_rst", s_x, 0);
            chk("s_y_rst", s_y, 0);
            chk("s_rgb_rst", s_rgb_out, 0);
            chk("s_fs_rst", s_fs, 0);
            chk("s_hsync_rst", s_hsync, 1);
            chk("s_vsync_rst", s_vsync, 1);
        end else begin
            p   = (n - S_L) % S_FR;
            h   = p % S_HT;
            v   = p / S_HT;
            act = (h < S_HD) && (v < S_VD);
            chk("s_de", s_de, act);
            chk("s_x", s_x, act ? h : 0);
            chk("s_y", s_y, act ? v : 0);
            chk("s_rgb", s_rgb_out, act ? pix_addr(h, v) : 0);
            chk("s_fs", s_fs, p == 0);
            chk("s_hsync", s_hsync, !(h >= 10 && h < 12));
            chk("s_vsync", s_vsync, !(v == 5));
        end
        if (reset || n < 1) begin
            chk("s_fb_rd_rst", s_fb_rd, 0);
            chk("s_fb_addr_rst", s_fb_addr, 0);
        end else begin
            p1   = (n - 1) % S_FR;
            h1   = p1 % S_HT;
            v1   = p1 / S_HT;
            act1 = (h1 < S_HD) && (v1 < S_VD);
            chk("s_fb_rd", s_fb_rd, act1);
            if (act1) chk("s_fb_addr", s_fb_addr, pix_addr(h1, v1));
        end
    endtask

    task automatic step(input logic pe);
        pix_en = pe;
        @(posedge clk);
        #1;
        if (pe && !reset) n++;
        if (pe && !reset && s_de === 1'b1) de_seen++;
        check_small();
        if (!reset) begin
            if (!prev2 && d_hsync) begin
                if (rise1 < 0) rise1 = n;
                else if (rise2 < 0) rise2 = n;
            end
            if (prev2 && !d_hsync && rise1 >= 0 && fall1 < 0) fall1 = n;
        end
        prev2 = d_hsync;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n     = 0;
        rise1 = -1;
        rise2 = -1;
        fall1 = -1;
        prev2 = 1'b0;
        check_small();
        chk("d_hsync_rst", d_hsync, 0);
        chk("d_vsync_rst", d_vsync, 0);
        chk("d_de_rst", d_de, 0);
        chk("d_fb_addr_rst", d_fb_addr, 0);
        step(1'b1);
        step(1'b1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        pix_en = 1'b0;
        do_reset();

        // One full frame at full rate: 32 active pixels
        de_seen = 0;
        for (int i = 0; i < S_FR + S_L - 1; i++) step(1'b1);
        chk("s_de_count_full", de_seen, 32);

        // pix_en 1-0-1-0: same frame stretched 2x, held during idle cycles
        de_seen = 0;
        for (int i = 0; i < 2 * S_FR; i++) step((i % 2) == 0);
        chk("s_de_count_half", de_seen, 32);

        // Reset in the middle of a line
        for (int i = 0; i < 30; i++) step(1'b1);
        do_reset();

        // Long run: small raster keeps wrapping, default hsync gets measured
        for (int i = 0; i < 1500; i++) step(1'b1);
        chk("d_hsync_first_rise", rise1, 659);
        chk("d_hsync_period", rise2 - rise1, 800);
        chk("d_hsync_width", fall1 - rise1, 96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with framebuffer fetch and latency-aligned pixel output; the successor to the fixed 640x480, 3-bit-colour controller. It owns the horizontal/vertical counters, issues linear framebuffer read addresses ahead of the beam to cover a configurable RAM read latency, and delays sync/blank so colour, sync and data-enable leave the block aligned. It sits between the framebuffer RAM and the VGA DAC/pins.

## Interface
- H_DISP, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_PW, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISP, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_PW, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- COLOR_W, 4, bits per colour channel
- ADDR_W, 19, framebuffer address width (must hold H_DISP*V_DISP-1)
- FETCH_LAT, 1, framebuffer read latency in pixel cycles (0..7)
- SYNC_POL, 0, sync active level (0 = active-low)
- clk  in  1  pixel-rate clock
- reset  in  1  asynchronous, active-high
- pix_en  in  1  pixel clock enable; all state advances only when high
- rgb_in  in  3*COLOR_W  framebuffer read data {R,G,B}
- fb_rd  out  1  framebuffer read strobe
- fb_addr  out  ADDR_W  framebuffer read address
- rgb_out  out  3*COLOR_W  pixel colour, zero when blanked
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- de  out  1  data enable (active video)
- x  out  10  column of current rgb_out pixel (0 when blanked)
- y  out  10  row of current rgb_out pixel (0 when blanked)
- frame_start  out  1  one-pix_en pulse at the first active pixel of a frame

## Operation
- H_TOTAL = H_DISP+H_FP+H_PW+H_BP, V_TOTAL likewise. hcnt runs 0..H_TOTAL-1; vcnt increments when hcnt wraps and runs 0..V_TOTAL-1.
- Per-axis region order: display [0, DISP), front porch, sync [DISP+FP, DISP+FP+PW), back porch.
- Stage 0 (counters): active = hcnt<H_DISP && vcnt<V_DISP.
- Stage 1: fb_rd = active; fb_addr = running linear address, incremented after each active pixel, cleared at hcnt=0,vcnt=0. Wraps only via that clear; never exceeds H_DISP*V_DISP-1.
- rgb_in is valid FETCH_LAT pix_en cycles after fb_rd/fb_addr are presented.
- Output stage: rgb_out registered from rgb_in when delayed active, else 0. hsync, vsync, de, x, y and frame_start come from stage-0 values delayed through a shift register of length L = FETCH_LAT+2, so all outputs describe the same pixel.
- Sync polarity: output level = SYNC_POL when in sync region, ~SYNC_POL otherwise.

## Timing
- Reset (async): hcnt=vcnt=0, fb_addr=0, fb_rd=0, pipeline cleared, rgb_out=0, de=0, x=y=0, frame_start=0, hsync=vsync=~SYNC_POL (inactive).
- After reset release, the first pix_en cycle is hcnt=0,vcnt=0; frame_start and de first rise L pix_en cycles later.
- pix_en low: every register holds, including the delay line; the latency counts pix_en cycles, not clk cycles.
- Reset mid-frame: immediate return to reset values; no partial-frame fetch continues.
- hsync continues during vertical blanking; de stays 0 throughout vertical blanking.
- Line wrap and frame wrap in the same cycle (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1): both counters return to 0 together.

## Configuration
- VGA_SCALE2_EN defined: pixel doubling. Framebuffer holds (H_DISP/2)x(V_DISP/2) pixels; fb_addr = (vcnt>>1)*(H_DISP/2) + (hcnt>>1); each address is read for 2 consecutive pixels on 2 consecutive lines; x/y still report full-resolution coordinates. H_DISP and V_DISP must be even.
- Undefined: 1:1 linear fetch as in Operation.

## Test plan
- Defaults, FETCH_LAT=1: count pix_en cycles between hsync falling edges = 800; between vsync falling edges = 420000; hsync low 96 cycles, vsync low 2 lines (1600 cycles).
- Small config H 8/2/2/2, V 4/1/1/1, FETCH_LAT=3, model RAM returning data=addr: rgb_out sequence per frame 0..31 with de high on exactly 32 pixels; x/y match the pixel index.
- pix_en toggled 1-0-1-0: outputs identical to the all-ones run, stretched 2x; no extra or dropped pixels.
- SYNC_POL=1: hsync/vsync idle low after reset, pulse high for H_PW/V_PW.
- Assert reset at vcnt=100 mid-line: all outputs at reset values within the same cycle; next frame_start exactly L+0 pix_en cycles after release, fb_addr restarts at 0.
- VGA_SCALE2_EN, small config: fb_addr per active line 0,0,1,1,2,2,3,3 repeated on two lines, then 4,4,5,5,...
